// File: rtl/elev_pkg.sv
// Shared encodings for the elevator state bus and request bits.
// The motor controller imports the same state constants to decode the bus.
package elev_pkg;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StFloor1   = 3'd1;
  localparam logic [2:0] StFloor2   = 3'd2;
  localparam logic [2:0] StGoingTo1 = 3'd3;
  localparam logic [2:0] StGoingTo2 = 3'd4;

  localparam int unsigned ReqF1 = 0;
  localparam int unsigned ReqF2 = 1;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: tick pulses one cycle every TICK_DIV clocks.
module tick_gen #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/elevator_sched.sv
// Two-floor elevator sequencer: request latch, travel/dwell timing, state bus.
// Define ELEV_DOOR_REOPEN_EN to let a current-floor call reload the door dwell.
module elevator_sched
  import elev_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50_000_000,
  parameter int unsigned TRAVEL_TICKS = 5,
  parameter int unsigned DOOR_TICKS   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       call_f1,
  input  logic       call_f2,
  output logic [2:0] state,
  output logic [2:0] counting_value,
  output logic       door_open,
  output logic [1:0] req_pending
);

  localparam int unsigned DwellW = (DOOR_TICKS > 0) ? $clog2(DOOR_TICKS + 1) : 1;
  localparam logic [DwellW-1:0] DwellLoad = DwellW'(DOOR_TICKS);
  localparam logic [2:0] TravelLoad = 3'(TRAVEL_TICKS);

  logic              tick;
  logic [2:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [1:0]        req_q, req_d;
  logic              door_q, door_d;
  logic              reopen;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

`ifdef ELEV_DOOR_REOPEN_EN
  assign reopen = ((state_q == StFloor1) && call_f1) || ((state_q == StFloor2) && call_f2);
`else
  assign reopen = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dwell_q <= '0;
      req_q   <= '0;
      door_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      req_q   <= req_d;
      door_q  <= door_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    req_d   = req_q;

    case (state_q)
      StIdle: begin
        state_d = StFloor1;
        dwell_d = DwellLoad;
        req_d   = '0;
      end
      StFloor1: begin
        if (call_f2) req_d[ReqF2] = 1'b1;
        if (tick && (dwell_q != '0)) dwell_d = dwell_q - 1'b1;
        if (reopen) dwell_d = DwellLoad;
        // Destination bit is consumed at departure; the trip itself serves it.
        if ((dwell_q == '0) && req_q[ReqF2] && !reopen) begin
          state_d      = StGoingTo2;
          cnt_d        = TravelLoad;
          req_d[ReqF2] = 1'b0;
        end
      end
      StFloor2: begin
        if (call_f1) req_d[ReqF1] = 1'b1;
        if (tick && (dwell_q != '0)) dwell_d = dwell_q - 1'b1;
        if (reopen) dwell_d = DwellLoad;
        if ((dwell_q == '0) && req_q[ReqF1] && !reopen) begin
          state_d      = StGoingTo1;
          cnt_d        = TravelLoad;
          req_d[ReqF1] = 1'b0;
        end
      end
      StGoingTo1: begin
        if (call_f2) req_d[ReqF2] = 1'b1;
        // Zero is held for one full cycle so the motor controller sees a stop.
        if (cnt_q != '0) begin
          if (tick) cnt_d = cnt_q - 1'b1;
        end else begin
          state_d      = StFloor1;
          dwell_d      = DwellLoad;
          req_d[ReqF1] = 1'b0;
        end
      end
      StGoingTo2: begin
        if (call_f1) req_d[ReqF1] = 1'b1;
        if (cnt_q != '0) begin
          if (tick) cnt_d = cnt_q - 1'b1;
        end else begin
          state_d      = StFloor2;
          dwell_d      = DwellLoad;
          req_d[ReqF2] = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        dwell_d = '0;
        req_d   = '0;
      end
    endcase

    door_d = (dwell_d != '0) && ((state_d == StFloor1) || (state_d == StFloor2));
  end

  always_comb begin
    state          = state_q;
    counting_value = cnt_q;
    door_open      = door_q;
    req_pending    = req_q;
  end

endmodule

// File: tb/tb_elevator_sched.sv
// Scoreboarded bench for elevator_sched: expected output sequences are queued
// with each stimulus and compared as the DUT's outputs change.
module tb_elevator_sched;

  logic       clk = 1'b0;
  logic       rst, call_f1, call_f2;
  logic [2:0] state, counting_value;
  logic       door_open;
  logic [1:0] req_pending;

  logic       rst0, c0_f1, c0_f2;
  logic [2:0] state0, cv0;
  logic       door0;
  logic [1:0] req0;

  always #5 clk = ~clk;

  elevator_sched #(
    .TICK_DIV     (4),
    .TRAVEL_TICKS (3),
    .DOOR_TICKS   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .call_f1        (call_f1),
    .call_f2        (call_f2),
    .state          (state),
    .counting_value (counting_value),
    .door_open      (door_open),
    .req_pending    (req_pending)
  );

  elevator_sched #(
    .TICK_DIV     (4),
    .TRAVEL_TICKS (3),
    .DOOR_TICKS   (0)
  ) dut0 (
    .clk            (clk),
    .rst            (rst0),
    .call_f1        (c0_f1),
    .call_f2        (c0_f2),
    .state          (state0),
    .counting_value (cv0),
    .door_open      (door0),
    .req_pending    (req0)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] cv;
    logic       door;
    logic [1:0] req;
  } obs_t;

  typedef struct {
    obs_t o;
    int   dmin;
    int   dmax;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  obs_t last_o, mon_cur;
  exp_t mon_e;
  int   last_dmin, last_dmax, dur;
  bit   mon_en = 1'b0;
  bit   door0_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // dmax == 0 means the hold time of this observation is not checked.
  task automatic push(input logic [2:0] st, input logic [2:0] cv, input logic door,
                      input logic [1:0] req, input int dmin, input int dmax);
    exp_t e;
    e.o    = {st, cv, door, req};
    e.dmin = dmin;
    e.dmax = dmax;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_cur = {state, counting_value, door_open, req_pending};
      if (mon_cur !== last_o) begin
        if (last_dmax != 0) begin
          check_eq("hold_len", dur,
                   (dur < last_dmin) ? last_dmin : ((dur > last_dmax) ? last_dmax : dur));
        end
        if (sb_q.size() == 0) begin
          check_eq("unexp_change", mon_cur, last_o);
          last_dmin = 0;
          last_dmax = 0;
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("sb_obs", mon_cur, mon_e.o);
          last_dmin = mon_e.dmin;
          last_dmax = mon_e.dmax;
        end
        last_o = mon_cur;
        dur    = 1;
      end else begin
        dur++;
      end
    end
  end

  always @(negedge clk) begin
    if (door0 === 1'b1) door0_seen = 1'b1;
  end

  task automatic pulse(input logic f1, input logic f2);
    call_f1 = f1;
    call_f2 = f2;
    @(negedge clk);
    call_f1 = 1'b0;
    call_f2 = 1'b0;
  endtask

  task automatic pulse0(input logic f1, input logic f2);
    c0_f1 = f1;
    c0_f2 = f2;
    @(negedge clk);
    c0_f1 = 1'b0;
    c0_f2 = 1'b0;
  endtask

  task automatic wait_st(input bit use0, input logic [2:0] st, input bit use_cv,
                         input logic [2:0] cv, input int budget);
    logic [2:0] s, c;
    for (int i = 0; i < budget; i++) begin
      s = use0 ? state0 : state;
      c = use0 ? cv0 : counting_value;
      if ((s === st) && (!use_cv || (c === cv))) return;
      @(negedge clk);
    end
    s = use0 ? state0 : state;
    check_eq("wait_timeout", s, st);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0) return;
      @(negedge clk);
    end
    check_eq("sb_drain", sb_q.size(), 0);
    sb_q.delete();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; call_f1 = 1'b0; call_f2 = 1'b0;
    rst0 = 1'b1; c0_f1 = 1'b0; c0_f2 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state and release
    check_eq("rst_state", state, 3'd0);
    check_eq("rst_cv", counting_value, 3'd0);
    check_eq("rst_door", door_open, 1'b0);
    check_eq("rst_req", req_pending, 2'b00);
    last_o = '0; last_dmin = 0; last_dmax = 0; dur = 0;
    mon_en = 1'b1;
    push(3'd1, 3'd0, 1'b1, 2'b00, 5, 8);
    push(3'd1, 3'd0, 1'b0, 2'b00, 0, 0);
    rst = 1'b0;
    check_eq("idle_cycle", state, 3'd0);
    @(negedge clk);
    check_eq("home_f1", state, 3'd1);
    drain(60);

    // Travel up
    push(3'd1, 3'd0, 1'b0, 2'b10, 1, 1);
    push(3'd4, 3'd3, 1'b0, 2'b00, 1, 4);
    push(3'd4, 3'd2, 1'b0, 2'b00, 4, 4);
    push(3'd4, 3'd1, 1'b0, 2'b00, 4, 4);
    push(3'd4, 3'd0, 1'b0, 2'b00, 1, 1);
    push(3'd2, 3'd0, 1'b1, 2'b00, 5, 8);
    push(3'd2, 3'd0, 1'b0, 2'b00, 0, 0);
    pulse(1'b0, 1'b1);
    drain(100);
    check_eq("up_state", state, 3'd2);
    check_eq("up_req", req_pending, 2'b00);

    // Return to floor 1
    push(3'd2, 3'd0, 1'b0, 2'b01, 1, 1);
    push(3'd3, 3'd3, 1'b0, 2'b00, 1, 4);
    push(3'd3, 3'd2, 1'b0, 2'b00, 4, 4);
    push(3'd3, 3'd1, 1'b0, 2'b00, 4, 4);
    push(3'd3, 3'd0, 1'b0, 2'b00, 1, 1);
    push(3'd1, 3'd0, 1'b1, 2'b00, 5, 8);
    push(3'd1, 3'd0, 1'b0, 2'b00, 0, 0);
    pulse(1'b1, 1'b0);
    drain(100);

    // Mid-trip calls during GOING_TO_2
    push(3'd1, 3'd0, 1'b0, 2'b10, 1, 1);
    push(3'd4, 3'd3, 1'b0, 2'b00, 1, 4);
    push(3'd4, 3'd2, 1'b0, 2'b00, 1, 1);
    push(3'd4, 3'd2, 1'b0, 2'b01, 3, 3);
    push(3'd4, 3'd1, 1'b0, 2'b01, 4, 4);
    push(3'd4, 3'd0, 1'b0, 2'b01, 1, 1);
    push(3'd2, 3'd0, 1'b1, 2'b01, 5, 8);
    push(3'd2, 3'd0, 1'b0, 2'b01, 1, 1);
    push(3'd3, 3'd3, 1'b0, 2'b00, 1, 4);
    push(3'd3, 3'd2, 1'b0, 2'b00, 4, 4);
    push(3'd3, 3'd1, 1'b0, 2'b00, 4, 4);
    push(3'd3, 3'd0, 1'b0, 2'b00, 1, 1);
    push(3'd1, 3'd0, 1'b1, 2'b00, 5, 8);
    push(3'd1, 3'd0, 1'b0, 2'b00, 0, 0);
    pulse(1'b0, 1'b1);
    wait_st(1'b0, 3'd4, 1'b1, 3'd2, 40);
    call_f1 = 1'b1;
    call_f2 = 1'b1;
    @(negedge clk);
    call_f1 = 1'b0;
    call_f2 = 1'b0;
    check_eq("mid_req", req_pending, 2'b01);
    drain(150);
    check_eq("mid_end_state", state, 3'd1);

    // Current-floor call with the door closed
`ifdef ELEV_DOOR_REOPEN_EN
    push(3'd1, 3'd0, 1'b1, 2'b00, 5, 8);
    push(3'd1, 3'd0, 1'b0, 2'b00, 0, 0);
    pulse(1'b1, 1'b0);
    drain(60);
`else
    pulse(1'b1, 1'b0);
    repeat (12) @(negedge clk);
`endif
    check_eq("cur_floor_door", door_open, 1'b0);
    check_eq("cur_floor_req", req_pending, 2'b00);

    // Reset mid-trip; both calls at FLOOR1 latch only bit1
    push(3'd1, 3'd0, 1'b0, 2'b10, 1, 1);
    push(3'd4, 3'd3, 1'b0, 2'b00, 1, 4);
    push(3'd4, 3'd2, 1'b0, 2'b00, 1, 1);
    push(3'd0, 3'd0, 1'b0, 2'b00, 1, 1);
    push(3'd1, 3'd0, 1'b1, 2'b00, 5, 8);
    push(3'd1, 3'd0, 1'b0, 2'b00, 0, 0);
`ifdef ELEV_DOOR_REOPEN_EN
    pulse(1'b0, 1'b1);
`else
    pulse(1'b1, 1'b1);
`endif
    wait_st(1'b0, 3'd4, 1'b1, 3'd2, 40);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_state", state, 3'd0);
    check_eq("mid_rst_cv", counting_value, 3'd0);
    check_eq("mid_rst_req", req_pending, 2'b00);
    check_eq("mid_rst_door", door_open, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_state", state, 3'd1);
    check_eq("post_rst_req", req_pending, 2'b00);
    drain(60);

    // DOOR_TICKS = 0: departure the cycle after arriving at FLOOR1
    rst0 = 1'b0;
    wait_st(1'b1, 3'd1, 1'b0, 3'd0, 10);
    pulse0(1'b0, 1'b1);
    wait_st(1'b1, 3'd4, 1'b0, 3'd0, 10);
    pulse0(1'b1, 1'b0);
    wait_st(1'b1, 3'd2, 1'b0, 3'd0, 40);
    @(negedge clk);
    check_eq("b0_leave_f2", state0, 3'd3);
    pulse0(1'b0, 1'b1);
    wait_st(1'b1, 3'd1, 1'b0, 3'd0, 40);
    check_eq("b0_arrive_door", door0, 1'b0);
    @(negedge clk);
    check_eq("b0_leave_f1", state0, 3'd4);
    check_eq("b0_leave_cv", cv0, 3'd3);
    check_eq("b0_door_never", door0_seen, 1'b0);

    mon_en = 1'b0;
    check_eq("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
